// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM status in, stage enables/flushes out.
// Latency: none, wires only.
// Backpressure: the unit's enables are the pipeline backpressure; this bundle only carries them.
//
// Ports (slave = hazard unit, master = pipeline/datapath):
//   IF_ID_Rs1/Rs2, IF_ID_UsesRs1/UsesRs2 : operands of the instruction in ID
//   ID_EX_Rd, ID_EX_MemRead              : destination / load flag of the instruction in EX
//   EX_MEM_MemRead/MemWrite              : data access of the instruction in MEM
//   branch_taken                         : taken branch/jump resolved in EX
//   pc_en, if_id_en, id_ex_en, ex_mem_en : register load enables (0 = hold)
//   if_id_flush, id_ex_flush             : load a NOP (only meaningful with enable = 1)
//   mem_owner                            : shared memory port owner, 0 = fetch, 1 = data
//   stall_cycles                         : saturating count of stalled fetch cycles
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  IF_ID_Rs1;
    logic [REG_ADDR_W-1:0]  IF_ID_Rs2;
    logic                   IF_ID_UsesRs1;
    logic                   IF_ID_UsesRs2;
    logic [REG_ADDR_W-1:0]  ID_EX_Rd;
    logic                   ID_EX_MemRead;
    logic                   EX_MEM_MemRead;
    logic                   EX_MEM_MemWrite;
    logic                   branch_taken;
    logic                   pc_en;
    logic                   if_id_en;
    logic                   id_ex_en;
    logic                   ex_mem_en;
    logic                   if_id_flush;
    logic                   id_ex_flush;
    logic                   mem_owner;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
        output ID_EX_Rd, ID_EX_MemRead, EX_MEM_MemRead, EX_MEM_MemWrite, branch_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
        input  mem_owner, stall_cycles
    );

    modport slave (
        input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
        input  ID_EX_Rd, ID_EX_MemRead, EX_MEM_MemRead, EX_MEM_MemWrite, branch_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
        output mem_owner, stall_cycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard/pipeline control for a 5-stage core sharing one memory port between fetch and data.
// Latency: controls are combinational from state+inputs; stall_cycles updates one edge later.
// Backpressure: data accesses freeze the pipe for MEM_LATENCY-1 cycles and block fetch for MEM_LATENCY cycles.
//
// Ports: clk, rst (synchronous, active-high); hz = hazard_control_unit_if.slave bundle
//   (ID/EX/MEM status in, pc/if_id/id_ex/ex_mem enables + flushes, mem_owner, stall_cycles out).
module hazard_control_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_USE_EN = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hz
);

    localparam int WCNT_W = $clog2(16);
    localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
    // Cycles left in MEM_WAIT after the one spent in IDLE, excluding the final cycle.
    localparam logic [WCNT_W-1:0] WAIT_INIT = MULTI_CYCLE ? WCNT_W'(MEM_LATENCY - 2) : '0;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [WCNT_W-1:0]      wcnt, wcnt_n;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic [REG_ADDR_W-1:0]  rs1, rs2, rd;
    logic                   dreq, lu, freeze, final_cyc;
    logic                   pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic                   if_id_flush, id_ex_flush, mem_owner;

    assign rs1  = hz.IF_ID_Rs1;
    assign rs2  = hz.IF_ID_Rs2;
    assign rd   = hz.ID_EX_Rd;
    assign dreq = hz.EX_MEM_MemRead | hz.EX_MEM_MemWrite;

    // x0 is never a real producer, so a load to x0 must not stall its consumer.
    assign lu = (LOAD_USE_EN != 0) && hz.ID_EX_MemRead && (rd != '0) &&
                ((hz.IF_ID_UsesRs1 && (rs1 == rd)) || (hz.IF_ID_UsesRs2 && (rs2 == rd)));

    // Next state and cycle classification.
    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        freeze    = 1'b0;
        final_cyc = 1'b0;
        case (state)
            IDLE: begin
                if (dreq) begin
                    if (MULTI_CYCLE) begin
                        freeze  = 1'b1;
                        state_n = MEM_WAIT;
                        wcnt_n  = WAIT_INIT;
                    end else begin
                        final_cyc = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (wcnt != '0) begin
                    freeze = 1'b1;
                    wcnt_n = wcnt - 1'b1;
                end else begin
                    final_cyc = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                wcnt_n  = '0;
            end
        endcase
    end

    // Stage controls. While in reset the pipe runs freely with fetch owning memory.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_owner   = 1'b0;
        if (!rst) begin
            if (freeze) begin
                // Whole pipe holds; EX keeps presenting branch/load-use until the final cycle.
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_owner = 1'b1;
            end else if (final_cyc) begin
                mem_owner = 1'b1;
                if (hz.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else begin
                    // Fetch lost the port this cycle: PC holds, ID receives a bubble.
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
            end else begin
                if (hz.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.mem_owner    = mem_owner;
    assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three latency variants (1,2,3) plus a 2-bit counter / no-interlock variant.
// Latency: outputs sampled 1 time unit after inputs change, between clock edges.
// Backpressure: n/a.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, idmr, exr, exw, br;

    // Control vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_owner}
    localparam logic [6:0] RUN    = 7'b1111_00_0;
    localparam logic [6:0] LU     = 7'b0011_01_0;
    localparam logic [6:0] BR     = 7'b1111_11_0;
    localparam logic [6:0] FRZ    = 7'b0000_00_1;
    localparam logic [6:0] FIN    = 7'b0111_10_1;
    localparam logic [6:0] FIN_LU = 7'b0011_01_1;
    localparam logic [6:0] FIN_BR = 7'b1111_11_1;

    logic [6:0]  ctl [3];
    logic [15:0] cnt [3];
    logic [6:0]  sat_ctl;
    logic [1:0]  sat_cnt;

    hazard_control_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) hif [3] ();
    hazard_control_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(2))  hifs ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hif[g].IF_ID_Rs1       = rs1;
        assign hif[g].IF_ID_Rs2       = rs2;
        assign hif[g].IF_ID_UsesRs1   = u1;
        assign hif[g].IF_ID_UsesRs2   = u2;
        assign hif[g].ID_EX_Rd        = rd;
        assign hif[g].ID_EX_MemRead   = idmr;
        assign hif[g].EX_MEM_MemRead  = exr;
        assign hif[g].EX_MEM_MemWrite = exw;
        assign hif[g].branch_taken    = br;
        assign ctl[g] = {hif[g].pc_en, hif[g].if_id_en, hif[g].id_ex_en, hif[g].ex_mem_en,
                         hif[g].if_id_flush, hif[g].id_ex_flush, hif[g].mem_owner};
        assign cnt[g] = hif[g].stall_cycles;

        hazard_control_unit #(
            .MEM_LATENCY (g + 1),
            .REG_ADDR_W  (5),
            .LOAD_USE_EN (1),
            .STALL_CNT_W (16)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .hz  (hif[g])
        );
    end

    assign hifs.IF_ID_Rs1       = rs1;
    assign hifs.IF_ID_Rs2       = rs2;
    assign hifs.IF_ID_UsesRs1   = u1;
    assign hifs.IF_ID_UsesRs2   = u2;
    assign hifs.ID_EX_Rd        = rd;
    assign hifs.ID_EX_MemRead   = idmr;
    assign hifs.EX_MEM_MemRead  = exr;
    assign hifs.EX_MEM_MemWrite = exw;
    assign hifs.branch_taken    = br;
    assign sat_ctl = {hifs.pc_en, hifs.if_id_en, hifs.id_ex_en, hifs.ex_mem_en,
                      hifs.if_id_flush, hifs.id_ex_flush, hifs.mem_owner};
    assign sat_cnt = hifs.stall_cycles;

    hazard_control_unit #(
        .MEM_LATENCY (1),
        .REG_ADDR_W  (5),
        .LOAD_USE_EN (0),
        .STALL_CNT_W (2)
    ) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (hifs)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1 = '0; rs2 = '0; rd = '0;
        u1 = 1'b0; u2 = 1'b0; idmr = 1'b0; exr = 1'b0; exw = 1'b0; br = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       idmr;
        logic       exr;
        logic       exw;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit done;

        // rs1  rs2  u1 u2 rd  idmr exr exw br  expected (latency-1 unit, IDLE)
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN};
        tbl[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        tbl[2]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, RUN};
        tbl[3]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RUN};
        tbl[4]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        tbl[5]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, RUN};
        tbl[6]  = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, RUN};
        tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BR};
        tbl[8]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, BR};
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FIN};
        tbl[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FIN_LU};
        tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, FIN_BR};

        // Reset state: outputs forced to free-running while rst = 1, counter cleared.
        clear_inputs();
        exr = 1'b1;
        br  = 1'b1;
        #1;
        chk("rst_ctl_l1", 32'(ctl[0]), 32'(RUN));
        chk("rst_ctl_l3", 32'(ctl[2]), 32'(RUN));
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        chk("rst_cnt_l1", 32'(cnt[0]), 32'd0);
        chk("rst_cnt_sat", 32'(sat_cnt), 32'd0);
        rst = 1'b0;

        // Combinational vectors on the latency-1 unit, which stays in IDLE throughout.
        foreach (tbl[i]) begin
            @(negedge clk);
            rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; u1 = tbl[i].u1; u2 = tbl[i].u2;
            rd = tbl[i].rd; idmr = tbl[i].idmr; exr = tbl[i].exr; exw = tbl[i].exw; br = tbl[i].br;
            #1;
            chk($sformatf("vec%0d", i), 32'(ctl[0]), 32'(tbl[i].exp));
        end

        // Latency 1, single load pulse.
        do_reset();
        exr = 1'b1;
        #1;
        chk("l1_load_final", 32'(ctl[0]), 32'(FIN));
        @(negedge clk);
        exr = 1'b0;
        #1;
        chk("l1_load_after", 32'(ctl[0]), 32'(RUN));
        chk("l1_load_cnt", 32'(cnt[0]), 32'd1);

        // Latency 3, store held until the back end advances.
        do_reset();
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (i != 0) @(negedge clk);
            exw = 1'b1;
            #1;
            n++;
            if (ctl[2][3]) begin
                done = 1'b1;
                chk("l3_final", 32'(ctl[2]), 32'(FIN));
            end else begin
                chk($sformatf("l3_freeze%0d", n), 32'(ctl[2]), 32'(FRZ));
            end
        end
        chk("l3_cycles", 32'(n), 32'd3);
        @(negedge clk);
        exw = 1'b0;
        #1;
        chk("l3_idle", 32'(ctl[2]), 32'(RUN));
        chk("l3_cnt", 32'(cnt[2]), 32'd3);

        // Latency 2, load-use resolved on the final data cycle.
        do_reset();
        exr = 1'b1; idmr = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1;
        #1;
        chk("l2_lu_freeze", 32'(ctl[1]), 32'(FRZ));
        @(negedge clk);
        #1;
        chk("l2_lu_final", 32'(ctl[1]), 32'(FIN_LU));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("l2_lu_after", 32'(ctl[1]), 32'(RUN));
        chk("l2_lu_cnt", 32'(cnt[1]), 32'd2);

        // Latency 2, branch held during the access.
        do_reset();
        exw = 1'b1; br = 1'b1;
        #1;
        chk("l2_br_freeze", 32'(ctl[1]), 32'(FRZ));
        @(negedge clk);
        #1;
        chk("l2_br_final", 32'(ctl[1]), 32'(FIN_BR));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("l2_br_after", 32'(ctl[1]), 32'(RUN));
        chk("l2_br_cnt", 32'(cnt[1]), 32'd1);

        // Latency 3, reset while in MEM_WAIT abandons the access.
        do_reset();
        exr = 1'b1;
        #1;
        chk("l3_rst_freeze0", 32'(ctl[2]), 32'(FRZ));
        @(negedge clk);
        #1;
        chk("l3_rst_freeze1", 32'(ctl[2]), 32'(FRZ));
        rst = 1'b1;
        #1;
        chk("l3_rst_force", 32'(ctl[2]), 32'(RUN));
        @(negedge clk);
        rst = 1'b0;
        exr = 1'b0;
        #1;
        chk("l3_rst_idle", 32'(ctl[2]), 32'(RUN));
        chk("l3_rst_cnt", 32'(cnt[2]), 32'd0);

        // Saturation of the 2-bit counter over five back-to-back accesses.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            exr = 1'b1;
            #1;
            chk($sformatf("sat_final%0d", i), 32'(sat_ctl), 32'(FIN));
        end
        @(negedge clk);
        exr = 1'b0;
        #1;
        chk("sat_cnt", 32'(sat_cnt), 32'd3);
        chk("l1_b2b_cnt", 32'(cnt[0]), 32'd5);

        // Interlock disabled on the saturation unit: same hazard stalls only the enabled unit.
        @(negedge clk);
        idmr = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1;
        #1;
        chk("lu_disabled", 32'(sat_ctl), 32'(RUN));
        chk("lu_enabled", 32'(ctl[0]), 32'(LU));
        @(negedge clk);
        clear_inputs();
        #1;
        chk("lu_one_bubble_cnt", 32'(cnt[0]), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard and pipeline-control unit for the 5-stage RV32 core with a single shared instruction/data memory port. It replaces the single-cycle structural-stall logic with a latency-aware memory-arbitration FSM. It adds load-use interlock with per-operand qualification, EX-stage branch flush, and a saturating stall-cycle performance counter. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers plus the memory-port owner select.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles a data access occupies the shared memory port; legal range 1..16.
- REG_ADDR_W, 5: register-address width.
- LOAD_USE_EN, 1: 1 enables load-use interlock; 0 ties the detect term to 0.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IF_ID_Rs1, IF_ID_Rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- IF_ID_UsesRs1, IF_ID_UsesRs2  in  1  operand actually read by the instruction in ID.
- ID_EX_Rd  in  REG_ADDR_W  destination of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1  instruction in MEM accesses data memory.
- branch_taken  in  1  taken branch or jump resolved in EX.
- pc_en  out  1  PC load enable (0 = hold).
- if_id_en, id_ex_en, ex_mem_en  out  1  pipeline register enables (0 = hold).
- if_id_flush, id_ex_flush  out  1  load a NOP into the register (valid only when its enable is 1).
- mem_owner  out  1  memory-port owner: 0 = fetch, 1 = data.
- stall_cycles  out  STALL_CNT_W  count of cycles with pc_en = 0 that are not branch cycles.

## Operation
- FSM states: IDLE and MEM_WAIT. There is a wait counter `wcnt` of width clog2(16).
- A data request is `dreq = EX_MEM_MemRead | EX_MEM_MemWrite`.
- A load-use hazard is `lu = LOAD_USE_EN & ID_EX_MemRead & (ID_EX_Rd != 0) & ((UsesRs1 & Rs1 == Rd) | (UsesRs2 & Rs2 == Rd))`.
- **Freeze cycle:** in IDLE with dreq and MEM_LATENCY > 1, or in MEM_WAIT with wcnt != 0.
  - Outputs: all four enables = 0, flushes = 0, mem_owner = 1.
  - branch_taken and lu are ignored. The frozen EX stage keeps presenting them.
- **Final data cycle:** in IDLE with dreq and MEM_LATENCY = 1, or in MEM_WAIT with wcnt = 0.
  - Outputs: mem_owner = 1, ex_mem_en = 1, id_ex_en = 1.
  - Resolve in priority order:
    1. branch_taken: pc_en = 1, if_id_flush = 1, id_ex_flush = 1.
    2. lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
    3. Otherwise: pc_en = 0, if_id_en = 1, if_id_flush = 1 (the fetch slot is lost).
- **Normal cycle:** IDLE without dreq.
  - Outputs: mem_owner = 0, ex_mem_en = 1, id_ex_en = 1.
  - branch_taken: pc_en = 1, if_id_en = 1, if_id_flush = 1, id_ex_flush = 1.
  - Else lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - Else all enables = 1, flushes = 0.
- **Transitions:**
  - IDLE & dreq & MEM_LATENCY > 1 → MEM_WAIT, with wcnt ← MEM_LATENCY − 2.
  - MEM_WAIT & wcnt != 0 → wcnt decrements.
  - MEM_WAIT & wcnt = 0 → IDLE.
- **Back-to-back accesses:** a new dreq seen in IDLE right after a final cycle starts a fresh access. This is a new instruction, so it is not a re-trigger.
- **Counter:** stall_cycles increments on every cycle with pc_en = 0, saturates at all-ones, and never wraps.
- All outputs except stall_cycles are combinational from state and inputs.

## Timing
- Reset: state IDLE, wcnt = 0, stall_cycles = 0 after the edge with rst = 1.
- While rst = 1: all enables = 1, flushes = 0, mem_owner = 0, and stall_cycles does not increment.
- Reset asserted during MEM_WAIT: the access is abandoned and the FSM is in IDLE on the next edge.
- Per data access, the fetch is blocked for exactly MEM_LATENCY cycles and the back end is frozen for MEM_LATENCY − 1 cycles.
- With MEM_LATENCY = 1 there is exactly one stall cycle per access; the FSM never leaves IDLE.
- Load-use costs exactly one bubble. The hazard term is 0 on the cycle after the bubble because ID_EX_MemRead is then 0.
- Branch penalty is 2 squashed slots and adds no stall_cycles increments.

## Test plan
- **Latency 1, single load:** MEM_LATENCY = 1, EX_MEM_MemRead pulsed for 1 cycle → for that cycle pc_en = 0, if_id_flush = 1, mem_owner = 1; next cycle all enables = 1; stall_cycles = 1.
- **Latency 3, single load:** MEM_LATENCY = 3, EX_MEM_MemWrite held until ex_mem_en = 1 → 2 full-freeze cycles, then 1 final cycle; mem_owner = 1 for 3 cycles; stall_cycles = 3; FSM back in IDLE.
- **Load-use detection:** ID_EX_MemRead = 1, ID_EX_Rd = 5, IF_ID_Rs2 = 5 with UsesRs2 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - Same with UsesRs2 = 0 → no stall.
  - Same with Rd = 0 → no stall.
- **Load-use during final data cycle:** MEM_LATENCY = 2, dreq and lu both present → cycle 1 is a freeze; cycle 2 gives if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1.
- **Branch during data access:** branch_taken held with dreq, MEM_LATENCY = 2 → cycle 1 is a freeze; cycle 2 gives pc_en = 1, both flushes = 1; stall_cycles increments by 1.
- **Reset mid-access and counter saturation:** rst during MEM_WAIT → IDLE, stall_cycles = 0.
  - STALL_CNT_W = 2 with 5 consecutive stalls → stall_cycles holds at 3.
